// File: rtl/usart_pkg.sv
// usart_pkg: definitions shared by the usart transmit and receive paths.
//
// Contents:
//   usart_state_t   - serial frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   USART_DATA_BITS - data bits per frame (8)
//   USART_MIN_CPB   - smallest usable clocks-per-bit; lower values are clamped up
package usart_pkg;

    localparam int USART_DATA_BITS = 8;
    localparam int USART_MIN_CPB   = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } usart_state_t;

endpackage

// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo: small synchronous byte FIFO feeding the transmit FSM.
//
// Ports:
//   clock      - system clock, rising edge
//   reset_n    - asynchronous active-low reset; empties the FIFO
//   push       - write push_data (ignored while full)
//   push_data  - entry to write
//   pop        - discard the head entry (ignored while empty)
//   pop_data   - current head entry (valid while !empty)
//   full/empty - occupancy flags
//   count      - current occupancy, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap on their own.
module usart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == DEPTH_CNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    // Head is read combinationally so the FSM can load it in the same
    // cycle it pops (needed for gap-free back-to-back frames).
    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/usart_tx_buffered.sv
// usart_tx_buffered: buffered 8N1 serial transmitter, LSB first.
//
// Ports:
//   clock          - system clock, rising edge
//   reset_n        - asynchronous active-low reset; aborts any frame
//   clocks_per_bit - bit period in clocks, sampled at frame start (0/1 -> 2)
//   data_in        - byte to queue
//   data_valid     - data_in is offered this cycle
//   parity_odd     - parity sense, latched at frame start (USART_TX_PARITY_EN only)
//   data_ready     - FIFO can take a byte (!full)
//   tx_pin         - registered serial output, idle high
//   tx_busy        - frame in progress or bytes waiting
//   fifo_count     - current FIFO occupancy
//
// Build option: define USART_TX_PARITY_EN to insert a parity bit between the
// last data bit and the stop bit (frames become 8E1/8O1).
module usart_tx_buffered
    import usart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CPB_WIDTH  = 12
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [CPB_WIDTH-1:0]          clocks_per_bit,
    input  logic [USART_DATA_BITS-1:0]    data_in,
    input  logic                          data_valid,
`ifdef USART_TX_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic                          data_ready,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = $clog2(USART_DATA_BITS);
    localparam logic [CPB_WIDTH-1:0] CPB_MIN  = CPB_WIDTH'(USART_MIN_CPB);
    localparam logic [CPB_WIDTH-1:0] CPB_ONE  = CPB_WIDTH'(1);
    localparam logic [BW-1:0]        LAST_BIT = BW'(USART_DATA_BITS - 1);
    localparam logic [BW-1:0]        BIT_ONE  = BW'(1);

    usart_state_t               state_reg;
    logic [USART_DATA_BITS-1:0] shift_reg;
    logic [BW-1:0]              bit_idx_reg;
    logic [CPB_WIDTH-1:0]       timer_reg;
    logic [CPB_WIDTH-1:0]       cpb_reg;
    logic                       tx_pin_reg;
`ifdef USART_TX_PARITY_EN
    logic                       parity_reg;
`endif

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [USART_DATA_BITS-1:0] fifo_data;
    logic [CPB_WIDTH-1:0]       cpb_eff;
    logic                       timer_done;

    assign data_ready = !fifo_full;
    assign fifo_push  = data_valid && data_ready;
    assign timer_done = (timer_reg == '0);
    assign cpb_eff    = (clocks_per_bit < CPB_MIN) ? CPB_MIN : clocks_per_bit;
    // A new frame is loaded from IDLE, or on the final stop-bit cycle so the
    // next start bit follows with no idle gap.
    assign fifo_pop   = !fifo_empty &&
                        ((state_reg == IDLE) || ((state_reg == STOP) && timer_done));
    assign tx_pin     = tx_pin_reg;
    assign tx_busy    = (state_reg != IDLE) || !fifo_empty;

    usart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (USART_DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            timer_reg   <= '0;
            cpb_reg     <= CPB_MIN;
            tx_pin_reg  <= 1'b1;
`ifdef USART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            // The line register follows the state one cycle behind; every
            // bit therefore still lasts exactly cpb cycles on the pin, and
            // the start bit appears the edge after the pop.
            case (state_reg)
                START:   tx_pin_reg <= 1'b0;
                DATA:    tx_pin_reg <= shift_reg[0];
`ifdef USART_TX_PARITY_EN
                PARITY:  tx_pin_reg <= parity_reg;
`endif
                default: tx_pin_reg <= 1'b1;
            endcase

            case (state_reg)
                IDLE: begin
                    // Loading is handled by the fifo_pop block below.
                end
                START: begin
                    if (timer_done) begin
                        state_reg   <= DATA;
                        bit_idx_reg <= '0;
                        timer_reg   <= cpb_reg - CPB_ONE;
                    end else begin
                        timer_reg <= timer_reg - CPB_ONE;
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        timer_reg <= cpb_reg - CPB_ONE;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx_reg == LAST_BIT) begin
`ifdef USART_TX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_ONE;
                        end
                    end else begin
                        timer_reg <= timer_reg - CPB_ONE;
                    end
                end
`ifdef USART_TX_PARITY_EN
                PARITY: begin
                    if (timer_done) begin
                        state_reg <= STOP;
                        timer_reg <= cpb_reg - CPB_ONE;
                    end else begin
                        timer_reg <= timer_reg - CPB_ONE;
                    end
                end
`endif
                STOP: begin
                    if (!timer_done) begin
                        timer_reg <= timer_reg - CPB_ONE;
                    end else if (fifo_empty) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Frame load overrides whatever the case above chose.
            if (fifo_pop) begin
                state_reg <= START;
                shift_reg <= fifo_data;
                cpb_reg   <= cpb_eff;
                timer_reg <= cpb_eff - CPB_ONE;
`ifdef USART_TX_PARITY_EN
                parity_reg <= (^fifo_data) ^ parity_odd;
`endif
            end
        end
    end

endmodule

// File: doc/usart_tx_buffered.md
Name: usart_tx_buffered

Overview:
- Buffered 8-bit asynchronous serial transmitter: the transmit-direction counterpart to the usart receive path.
- Accepts bytes on a valid/ready handshake into a small FIFO, then serialises each byte as 8N1, LSB first, on tx_pin.
- Bit period is set at run time by clocks_per_bit, the same encoding the existing usart blocks use.
- Sits between a host-side byte producer (CPU bus bridge, echo loop) and the board TX pin.

Parameters:
- FIFO_DEPTH, 4, entries in the byte FIFO; power of two, minimum 2.
- CPB_WIDTH, 12, width of clocks_per_bit and of the internal bit timer.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clocks_per_bit  input  CPB_WIDTH  clock cycles per serial bit.
- data_in  input  8  byte to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  FIFO can accept a byte; equals !full.
- tx_pin  output  1  serial line; idle high.
- tx_busy  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - tx_pin=1, FIFO empty, fifo_count=0, data_ready=1, tx_busy=0, state=IDLE.
  - Asserting reset mid-frame aborts the frame immediately; tx_pin returns high and FIFO contents are discarded.
- Write: a byte is pushed when data_valid && data_ready at a rising edge. data_ready is combinational from full. Pushes while full are impossible because data_ready is low.
- Pop: the FSM pops only in IDLE or on the last cycle of STOP. A push and a pop in the same cycle are legal; fifo_count is unchanged. Push and pop when empty is not bypassed: the byte goes through the FIFO.
- FSM states:
  - IDLE: tx_pin=1. If FIFO is non-empty, pop into the shift register, latch cpb = max(clocks_per_bit, 2), go to START.
  - START: tx_pin=0 for cpb cycles, then go to DATA with bit_idx=0.
  - DATA: tx_pin=shift[0] for cpb cycles, then shift right and increment bit_idx. After bit 7 go to PARITY (if enabled) or STOP.
  - STOP: tx_pin=1 for cpb cycles. On the last cycle, if FIFO is non-empty, pop, relatch cpb and go to START (no extra idle cycles between frames); otherwise go to IDLE.
- Bit timer: counts down from cpb-1 to 0. Each bit lasts exactly cpb cycles.
  - clocks_per_bit is sampled only at frame start; changes mid-frame do not affect the current frame.
  - clocks_per_bit values 0 and 1 are treated as 2.
- tx_pin is registered (no glitches). Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE drives tx_pin low at edge N+2. That is one edge for the FIFO write and one for the IDLE pop and start-bit drive.
- Frame length: 10*cpb cycles (11*cpb with parity).
- tx_busy = (state!=IDLE) || (fifo_count!=0).

Optional Feature:
- Macro: USART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP, lasting cpb cycles, plus input parity_odd (1 bit).
  - tx_pin = ^byte ^ parity_odd, i.e. even parity when parity_odd=0.
  - parity_odd is latched at frame start.
- Undefined: no PARITY state and no parity_odd port; frames are 8N1 only.

Decomposition:
- Package usart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - USART_DATA_BITS=8;
  - USART_MIN_CPB=2.
  The receiver shares this package.
- One sub-module: usart_tx_fifo, a synchronous FIFO with push/pop, full/empty and count, async active-low reset.

Test Plan:
- cpb=64; push 0x75 -> tx_pin low at the second edge after accept. Over 640 cycles, sample bits at mid-bit: 0, 1,0,1,0,1,1,1,0, 1. Then tx_busy=0.
- cpb=64; push 0x75 then 0x8A back-to-back -> second start bit begins exactly 640 cycles after the first. Second byte's data bits are 0,1,0,1,0,0,0,1. No idle gap between frames.
- FIFO_DEPTH=4, cpb=16; push 6 bytes with data_valid held high:
  - 1 byte is popped; data_ready drops after 5 accepts;
  - a further byte is accepted each time a byte is popped;
  - all 6 bytes are transmitted in order.
- cpb=64; change clocks_per_bit to 8 mid-frame -> current frame keeps 64-cycle bits; next frame uses 8-cycle bits. clocks_per_bit=0 -> 2-cycle bits.
- Mid-DATA reset_n pulse -> tx_pin=1 asynchronously, fifo_count=0, data_ready=1. After release, the next pushed byte is sent correctly.
- USART_TX_PARITY_EN, parity_odd=0, cpb=64, push 0x75 (five ones) -> parity bit 1, then stop bit; frame length 704 cycles.
